// File: rtl/act_maxpool2x2_if.sv
// act_maxpool2x2_if: stream and configuration bundle for the 2x2 max-pool stage.
//
// Signals:
//   start       one-cycle pulse; samples config and (re)starts a frame
//   pool_en     1 = 2x2 max-pool, 0 = bypass
//   img_width   plane width in pixels
//   img_height  plane height in pixels
//   act_in      activation from the upstream stage (two's complement)
//   act_vld_in  act_in valid
//   act_out     pooled or bypassed activation
//   act_vld_out act_out valid (single-cycle pulse)
//   frame_done  one-cycle pulse after the last pixel of the plane
//   cfg_err     sticky config error flag
//
// Modports: master drives the configuration/input stream (upstream side),
//           slave is the pooling stage itself.
interface act_maxpool2x2_if #(
    parameter int unsigned ACT_BITS = 8,
    parameter int unsigned DIM_BITS = 9
);
    logic                start;
    logic                pool_en;
    logic [DIM_BITS-1:0] img_width;
    logic [DIM_BITS-1:0] img_height;
    logic [ACT_BITS-1:0] act_in;
    logic                act_vld_in;
    logic [ACT_BITS-1:0] act_out;
    logic                act_vld_out;
    logic                frame_done;
    logic                cfg_err;

    modport master (
        output start,
        output pool_en,
        output img_width,
        output img_height,
        output act_in,
        output act_vld_in,
        input  act_out,
        input  act_vld_out,
        input  frame_done,
        input  cfg_err
    );

    modport slave (
        input  start,
        input  pool_en,
        input  img_width,
        input  img_height,
        input  act_in,
        input  act_vld_in,
        output act_out,
        output act_vld_out,
        output frame_done,
        output cfg_err
    );
endinterface

// File: rtl/act_maxpool2x2.sv
// act_maxpool2x2: streaming 2x2 stride-2 signed max-pool with per-layer bypass.
//
// Consumes one activation per valid cycle in raster order (one channel plane
// per frame). Even rows are parked in a single-row line buffer; on odd rows the
// even column folds the buffered pixel into a pair register and the odd column
// completes the window and emits the maximum one cycle later.
//
// Ports:
//   clk   clock
//   rstn  asynchronous active-low reset
//   bus   act_maxpool2x2_if.slave: start/config, input stream, output stream,
//         frame_done pulse and sticky cfg_err
module act_maxpool2x2 #(
    parameter int unsigned ACT_BITS  = 8,
    parameter int unsigned MAX_WIDTH = 256,
    parameter int unsigned DIM_BITS  = 9
) (
    input logic              clk,
    input logic              rstn,
    act_maxpool2x2_if.slave  bus
);

    localparam int unsigned AddrBits = (MAX_WIDTH > 1) ? $clog2(MAX_WIDTH) : 1;

    typedef enum logic [1:0] {
        StIdle,
        StRun,
        StErr
    } state_e;

    state_e state_q, state_d;

    // Sampled configuration
    logic                pool_en_q;
    logic [DIM_BITS-1:0] width_q;
    logic [DIM_BITS-1:0] height_q;

    // Position of the pixel currently presented on act_in
    logic [DIM_BITS-1:0] col_q;
    logic [DIM_BITS-1:0] row_q;

    logic signed [ACT_BITS-1:0] pair_q;
    logic signed [ACT_BITS-1:0] linebuf [MAX_WIDTH];

    logic signed [ACT_BITS-1:0] act_out_q;
    logic                       act_vld_out_q;
    logic                       frame_done_q;

    logic signed [ACT_BITS-1:0] act_in_s;
    logic signed [ACT_BITS-1:0] lb_rd;
    logic [AddrBits-1:0]        col_idx;
    logic                       cfg_bad;
    logic                       last_col;
    logic                       last_row;
    logic                       run;
    logic                       cfg_err_c;
    logic                       accept;

    function automatic logic signed [ACT_BITS-1:0] smax(
        input logic signed [ACT_BITS-1:0] a,
        input logic signed [ACT_BITS-1:0] b
    );
        return (a > b) ? a : b;
    endfunction

    assign act_in_s = $signed(bus.act_in);
    assign col_idx  = col_q[AddrBits-1:0];
    assign lb_rd    = linebuf[col_idx];

    assign cfg_bad = (bus.img_width == '0) ||
                     (32'(bus.img_width) > MAX_WIDTH) ||
                     (bus.img_height == '0);

    assign last_col = (col_q == (width_q - DIM_BITS'(1)));
    assign last_row = (row_q == (height_q - DIM_BITS'(1)));

    // A start pulse always wins: the pixel presented in that cycle is dropped.
    assign accept = run && bus.act_vld_in && !bus.start;

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next state
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        if (bus.start) begin
            // start is honoured in every state, including an abort from StRun
            state_d = cfg_bad ? StErr : StRun;
        end else if (accept && last_col && last_row) begin
            state_d = StIdle;
        end
    end

    // ------------------------------------------------------------------
    // FSM: outputs
    // ------------------------------------------------------------------
    always_comb begin
        run       = 1'b0;
        cfg_err_c = 1'b0;
        unique case (state_q)
            StRun:   run       = 1'b1;
            StErr:   cfg_err_c = 1'b1;
            default: ;
        endcase
    end

    // ------------------------------------------------------------------
    // Config, counters and pair register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            pool_en_q <= 1'b0;
            width_q   <= '0;
            height_q  <= '0;
            col_q     <= '0;
            row_q     <= '0;
            pair_q    <= '0;
        end else if (bus.start) begin
            pool_en_q <= bus.pool_en;
            width_q   <= bus.img_width;
            height_q  <= bus.img_height;
            col_q     <= '0;
            row_q     <= '0;
            pair_q    <= '0;
        end else if (accept) begin
            if (last_col) begin
                col_q <= '0;
                row_q <= last_row ? '0 : row_q + DIM_BITS'(1);
            end else begin
                col_q <= col_q + DIM_BITS'(1);
            end
            // Odd row, even column: first half of the window
            if (pool_en_q && row_q[0] && !col_q[0]) begin
                pair_q <= smax(lb_rd, act_in_s);
            end
        end
    end

    // Line buffer holds the most recent even row; contents are never reset.
    always_ff @(posedge clk) begin
        if (accept && pool_en_q && !row_q[0]) begin
            linebuf[col_idx] <= act_in_s;
        end
    end

    // ------------------------------------------------------------------
    // Output registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            act_out_q     <= '0;
            act_vld_out_q <= 1'b0;
            frame_done_q  <= 1'b0;
        end else begin
            act_vld_out_q <= 1'b0;
            frame_done_q  <= accept && last_col && last_row;
            if (accept) begin
                if (!pool_en_q) begin
                    act_out_q     <= act_in_s;
                    act_vld_out_q <= 1'b1;
                end else if (row_q[0] && col_q[0]) begin
                    act_out_q     <= smax(pair_q, smax(lb_rd, act_in_s));
                    act_vld_out_q <= 1'b1;
                end
            end
        end
    end

    assign bus.act_out     = act_out_q;
    assign bus.act_vld_out = act_vld_out_q;
    assign bus.frame_done  = frame_done_q;
    assign bus.cfg_err     = cfg_err_c;

endmodule

// File: tb/tb_act_maxpool2x2.sv
// tb_act_maxpool2x2: directed self-checking bench for act_maxpool2x2.
// Inputs are driven and outputs sampled on the falling clock edge.
module tb_act_maxpool2x2;

    localparam int unsigned ACT_BITS  = 8;
    localparam int unsigned MAX_WIDTH = 256;
    localparam int unsigned DIM_BITS  = 9;

    logic clk  = 1'b0;
    logic rstn = 1'b0;

    always #5 clk = ~clk;

    act_maxpool2x2_if #(.ACT_BITS(ACT_BITS), .DIM_BITS(DIM_BITS)) bus ();

    act_maxpool2x2 #(
        .ACT_BITS (ACT_BITS),
        .MAX_WIDTH(MAX_WIDTH),
        .DIM_BITS (DIM_BITS)
    ) dut (
        .clk (clk),
        .rstn(rstn),
        .bus (bus)
    );

    int n_checks = 0;
    int n_errors = 0;
    int n_vld    = 0;
    int n_done   = 0;

    int p44[16] = '{1, -5, 3, 2, 0, 7, -8, -1, -3, -3, -128, -128, -2, -4, -128, -127};
    int e44[4]  = '{7, 3, -2, -127};
    int byp[6]  = '{-128, 127, 0, -1, 55, -77};

    // Output pulse counters
    always @(negedge clk) begin
        if (bus.act_vld_out === 1'b1) n_vld <= n_vld + 1;
        if (bus.frame_done === 1'b1) n_done <= n_done + 1;
    end

    task automatic chk(input string tag, input logic signed [31:0] obs,
                       input logic signed [31:0] exp_v);
        n_checks++;
        assert (obs === exp_v) else begin
            n_errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp_v);
        end
    endtask

    // One clock: present (vld, din), then check the registered outputs.
    task automatic step(input string tag, input logic vld, input int din,
                        input logic ev, input int eo, input logic ed);
        bus.act_vld_in = vld;
        bus.act_in     = ACT_BITS'(din);
        @(negedge clk);
        bus.act_vld_in = 1'b0;
        chk({tag, " vld"}, bus.act_vld_out, ev);
        if (ev) chk({tag, " out"}, $signed(bus.act_out), eo);
        chk({tag, " done"}, bus.frame_done, ed);
    endtask

    task automatic do_start(input logic pool, input int w, input int h);
        bus.start      = 1'b1;
        bus.pool_en    = pool;
        bus.img_width  = DIM_BITS'(w);
        bus.img_height = DIM_BITS'(h);
        bus.act_vld_in = 1'b0;
        @(negedge clk);
        bus.start = 1'b0;
    endtask

    task automatic run_pool4x4(input string tag, input bit gaps);
        int k = 0;
        for (int i = 0; i < 16; i++) begin
            automatic logic ev = (i == 5 || i == 7 || i == 13 || i == 15);
            step(tag, 1'b1, p44[i], ev, ev ? e44[k] : 0, i == 15);
            if (ev) k++;
            if (gaps && i != 15) begin
                for (int g = 0; g < (i % 3); g++) step({tag, " gap"}, 1'b0, 0, 1'b0, 0, 1'b0);
            end
        end
    endtask

    initial begin
        int base_vld;
        int base_done;
        int ng;
        bus.start      = 1'b0;
        bus.pool_en    = 1'b0;
        bus.img_width  = '0;
        bus.img_height = '0;
        bus.act_in     = '0;
        bus.act_vld_in = 1'b0;

        // Reset state
        @(negedge clk);
        chk("rst act_out", $signed(bus.act_out), 0);
        chk("rst act_vld_out", bus.act_vld_out, 0);
        chk("rst frame_done", bus.frame_done, 0);
        chk("rst cfg_err", bus.cfg_err, 0);
        rstn = 1'b1;

        // IDLE ignores input
        step("idle0", 1'b1, 42, 1'b0, 0, 1'b0);

        // Pool 4x4
        do_start(1'b1, 4, 4);
        chk("pool4x4 cfg_err", bus.cfg_err, 0);
        run_pool4x4("pool4x4", 1'b0);
        step("pool4x4 after", 1'b1, 99, 1'b0, 0, 1'b0);
        chk("hold act_out", $signed(bus.act_out), -127);

        // Reset in the middle of row 1
        do_start(1'b1, 4, 4);
        for (int i = 0; i < 5; i++) step("midrst feed", 1'b1, p44[i], 1'b0, 0, 1'b0);
        #2 rstn = 1'b0;
        #1;
        chk("midrst act_out", $signed(bus.act_out), 0);
        chk("midrst vld", bus.act_vld_out, 0);
        chk("midrst done", bus.frame_done, 0);
        chk("midrst cfg_err", bus.cfg_err, 0);
        @(negedge clk);
        rstn = 1'b1;
        step("midrst idle", 1'b1, 7, 1'b0, 0, 1'b0);
        do_start(1'b1, 4, 4);
        run_pool4x4("pool4x4 gaps", 1'b1);

        // Odd dimensions 5x3
        do_start(1'b1, 5, 3);
        for (int i = 0; i < 15; i++) begin
            automatic logic ev = (i == 6 || i == 8);
            step("odd5x3", 1'b1, i, ev, i, i == 14);
        end
        step("odd5x3 after", 1'b1, 3, 1'b0, 0, 1'b0);

        // Bypass 3x2 with random gaps
        do_start(1'b0, 3, 2);
        for (int i = 0; i < 6; i++) begin
            step("bypass", 1'b1, byp[i], 1'b1, byp[i], i == 5);
            ng = $urandom_range(0, 3);
            for (int g = 0; g < ng; g++) step("bypass gap", 1'b0, 0, 1'b0, 0, 1'b0);
        end
        step("bypass after", 1'b1, 5, 1'b0, 0, 1'b0);

        // Illegal configurations
        do_start(1'b1, MAX_WIDTH + 1, 4);
        chk("err wide cfg_err", bus.cfg_err, 1);
        for (int i = 0; i < 20; i++) step("err wide", 1'b1, i, 1'b0, 0, 1'b0);
        chk("err wide sticky", bus.cfg_err, 1);
        do_start(1'b1, 4, 0);
        chk("err h0 cfg_err", bus.cfg_err, 1);
        do_start(1'b1, 2, 2);
        chk("legal cfg_err", bus.cfg_err, 0);
        step("legal2x2", 1'b1, -7, 1'b0, 0, 1'b0);
        step("legal2x2", 1'b1, 5, 1'b0, 0, 1'b0);
        step("legal2x2", 1'b1, -100, 1'b0, 0, 1'b0);
        step("legal2x2", 1'b1, 3, 1'b1, 5, 1'b1);

        // Abort a 4x4 frame after 6 pixels, restart with 2x2
        do_start(1'b1, 4, 4);
        for (int i = 0; i < 6; i++) step("abort feed", 1'b1, p44[i], i == 5, 7, 1'b0);
        #1;
        base_vld  = n_vld;
        base_done = n_done;
        @(negedge clk);
        do_start(1'b1, 2, 2);
        step("abort2x2", 1'b1, 9, 1'b0, 0, 1'b0);
        step("abort2x2", 1'b1, -1, 1'b0, 0, 1'b0);
        step("abort2x2", 1'b1, 4, 1'b0, 0, 1'b0);
        step("abort2x2", 1'b1, 10, 1'b1, 10, 1'b1);
        for (int i = 0; i < 3; i++) step("abort tail", 1'b0, 0, 1'b0, 0, 1'b0);
        #1;
        chk("abort outputs", n_vld - base_vld, 1);
        chk("abort frame_done", n_done - base_done, 1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/act_maxpool2x2.md
Name: act_maxpool2x2

Overview:
- Streaming 2x2 stride-2 signed max-pool stage directly downstream of the bias/scale/activation stage.
- Consumes one ACT_BITS activation per valid cycle in raster order, one channel plane per frame.
- Emits pooled activations with a valid strobe toward the activation write buffer.
- Can be bypassed per layer (pool_en=0); a single-row line buffer holds even rows.

Parameters:
ACT_BITS, 8, activation width (two's complement)
MAX_WIDTH, 256, line-buffer depth = largest supported plane width
DIM_BITS, 9, width of the dimension registers and row/column counters

Ports:
clk  input  1  clock
rstn  input  1  asynchronous active-low reset
start  input  1  one-cycle pulse; samples config, clears counters, enters RUN
pool_en  input  1  1 = 2x2 max-pool, 0 = bypass (sampled at start)
img_width  input  DIM_BITS  plane width in pixels, 1..MAX_WIDTH (sampled at start)
img_height  input  DIM_BITS  plane height in pixels, >=1 (sampled at start)
act_in  input  ACT_BITS  activation from upstream stage
act_vld_in  input  1  act_in valid
act_out  output  ACT_BITS  pooled or bypassed activation
act_vld_out  output  1  act_out valid
frame_done  output  1  one-cycle pulse after the last input pixel of the frame is consumed
cfg_err  output  1  sticky until next start: sampled config illegal

Behaviour:
- Reset (async, rstn=0): state=IDLE; act_out=0, act_vld_out=0, frame_done=0, cfg_err=0; counters=0. Line-buffer contents are not reset.
- States:
  - IDLE: act_vld_in ignored. On start -> RUN, or -> ERR if img_width==0, img_width>MAX_WIDTH or img_height==0.
  - ERR: cfg_err=1; all inputs ignored. Exits only on the next start, which re-evaluates config and clears cfg_err.
  - RUN: counts col 0..W-1 and row 0..H-1 on each act_vld_in. After the pixel (H-1, W-1): frame_done=1 on the next cycle and state -> IDLE.
- start while in RUN aborts the frame: counters cleared, new config sampled, no frame_done, no partial output. Pair register and pending valid are dropped.
- Bypass (pool_en=0, RUN): act_out <= act_in, act_vld_out <= act_vld_in. Latency 1 cycle; every input produces an output.
- Pool (pool_en=1, RUN), on each valid input:
  - Even row: linebuf[col] <= act_in. No output.
  - Odd row, even col: pair <= smax(linebuf[col], act_in).
  - Odd row, odd col: act_out <= smax(pair, linebuf[col], act_in), act_vld_out=1 on the next cycle. Latency 1 cycle from the 4th window pixel.
  - All comparisons are signed. Ties are irrelevant because the output is a value, not an index.
- Odd W: the last column is consumed but never pooled. Odd H: the last row is consumed (written to linebuf) but never pooled. Output per plane = floor(W/2)*floor(H/2).
- act_vld_out and frame_done are single-cycle pulses. Both may be high in the same cycle when the last pixel completes a window.
- act_vld_in gaps of any length are allowed. Counters and pair hold during gaps.
- No backpressure: the downstream stage must accept every act_vld_out.
- act_out holds its last value when act_vld_out=0.

Test Plan:
- Reset mid-RUN: assert rstn=0 during row 1 -> outputs 0 immediately, state IDLE; next start with a 4x4 frame pools correctly.
- Pool 4x4, pixels row0=[1,-5,3,2], row1=[0,7,-8,-1], row2=[-3,-3,-128,-128], row3=[-2,-4,-128,-127] -> outputs 7,3,-2,-127 in order, each 1 cycle after its 4th pixel; frame_done 1 cycle after the last pixel, coincident with -127.
- Odd dims 5x3, all pixels = col+row*5 (values 0..14) -> outputs 6,8 only; 15 inputs consumed; frame_done after pixel 14.
- Bypass 3x2 with random act_vld_in gaps -> 6 outputs, each equal to its input, 1-cycle latency; frame_done after the 6th input.
- cfg_err: start with img_width=MAX_WIDTH+1 -> cfg_err=1, no outputs for 20 valid inputs. Next start with a legal 2x2 frame -> cfg_err=0 and one output.
- Abort: start a 4x4 frame, re-start after 6 pixels with a 2x2 frame [9,-1,4,10] -> single output 10, exactly one frame_done.
